// File: rtl/leaf_xbar_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | leaf_xbar_scheduler: round-robin burst grant scheduler for the leaf      |
// | crossbar (GPU + 4 spines). Optional stall watchdog: SCHED_TIMEOUT_EN.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module leaf_xbar_scheduler #(
    parameter int         ROUTER_ID      = 3,
    parameter logic [3:0] GROUP_ID       = 4'b0011,
    parameter int         LEN_W          = 4,
    parameter int         TIMEOUT_CYCLES = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               arb_enable,
    input  logic [4:0]         req_valid,
    input  logic [5*LEN_W-1:0] req_len,
    input  logic [5:0]         gpu_dest_addr,
    input  logic [3:0]         spine_ready,
    input  logic               beat_fire,
    output logic [2:0]         current_grant,
    output logic [4:0]         grant_onehot,
    output logic [1:0]         direction,
    output logic [1:0]         uplink_sel,
    output logic               busy,
    output logic               last_beat,
    output logic               timeout_err
);
    localparam logic [0:0] S_IDLE     = 1'b0;
    localparam logic [0:0] S_XFER     = 1'b1;
    localparam logic [2:0] NO_GRANT   = 3'b111;
    localparam logic [1:0] DIR_NONE   = 2'b00;
    localparam logic [1:0] DIR_UP     = 2'b01;
    localparam logic [1:0] DIR_DOWN   = 2'b10;
    localparam logic [1:0] DIR_LOOP   = 2'b11;
    localparam logic [5:0] LOCAL_ADDR = {GROUP_ID, 2'(ROUTER_ID)};

    function automatic logic [2:0] wrap5(input logic [2:0] a, input logic [2:0] b);
        logic [3:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= 4'd5) s = s - 4'd5;
        return s[2:0];
    endfunction

    logic [0:0]       state, state_nxt;
    logic [2:0]       rr_ptr, rr_ptr_nxt;
    logic [1:0]       uplink_ptr, uplink_ptr_nxt;
    logic [LEN_W-1:0] beats_left, beats_left_nxt;
    logic [2:0]       grant_nxt;
    logic [4:0]       onehot_nxt;
    logic [1:0]       dir_nxt, upsel_nxt;
    logic             busy_nxt, last_nxt, timeout_nxt;
    logic             gpu_local;
    logic [4:0]       eligible;
    logic [2:0]       winner;
    logic [1:0]       up_pick;
    logic [LEN_W-1:0] win_len;
    logic             start_grant, burst_done, timeout_hit;

    // Searches run backwards so the last hit is the first in round-robin order.
    always_comb begin
        gpu_local = (gpu_dest_addr == LOCAL_ADDR);
        up_pick   = uplink_ptr;
        for (int k = 3; k >= 0; k--) begin
            if (spine_ready[uplink_ptr + 2'(k)]) up_pick = uplink_ptr + 2'(k);
        end
        eligible = {req_valid[4:1], req_valid[0] && (gpu_local || (spine_ready != 4'b0000))};
        winner   = rr_ptr;
        for (int k = 4; k >= 0; k--) begin
            if (eligible[wrap5(rr_ptr, 3'(k))]) winner = wrap5(rr_ptr, 3'(k));
        end
        win_len = req_len[winner*LEN_W +: LEN_W];
    end

    assign start_grant = (state == S_IDLE) && arb_enable && (|eligible);
    assign burst_done  = (state == S_XFER) && beat_fire && (beats_left == '0);

`ifdef SCHED_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [STALL_W-1:0] stall_cnt;

    assign timeout_hit = (state == S_XFER) && !beat_fire
                         && (stall_cnt == STALL_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset || start_grant || beat_fire || timeout_hit || (state == S_IDLE))
            stall_cnt <= '0;
        else
            stall_cnt <= stall_cnt + 1'b1;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            rr_ptr        <= '0;
            uplink_ptr    <= '0;
            beats_left    <= '0;
            current_grant <= NO_GRANT;
            grant_onehot  <= '0;
            direction     <= DIR_NONE;
            uplink_sel    <= '0;
            busy          <= 1'b0;
            last_beat     <= 1'b0;
            timeout_err   <= 1'b0;
        end else begin
            state         <= state_nxt;
            rr_ptr        <= rr_ptr_nxt;
            uplink_ptr    <= uplink_ptr_nxt;
            beats_left    <= beats_left_nxt;
            current_grant <= grant_nxt;
            grant_onehot  <= onehot_nxt;
            direction     <= dir_nxt;
            uplink_sel    <= upsel_nxt;
            busy          <= busy_nxt;
            last_beat     <= last_nxt;
            timeout_err   <= timeout_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start_grant) state_nxt = S_XFER;
            S_XFER:  if (burst_done || timeout_hit) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // While busy, current_grant doubles as the latched winner.
    always_comb begin
        rr_ptr_nxt     = rr_ptr;
        uplink_ptr_nxt = uplink_ptr;
        beats_left_nxt = beats_left;
        grant_nxt      = current_grant;
        onehot_nxt     = grant_onehot;
        dir_nxt        = direction;
        upsel_nxt      = uplink_sel;
        busy_nxt       = busy;
        last_nxt       = last_beat;
        timeout_nxt    = 1'b0;
        if (start_grant) begin
            grant_nxt      = winner;
            onehot_nxt     = 5'b00001 << winner;
            busy_nxt       = 1'b1;
            beats_left_nxt = win_len;
            last_nxt       = (win_len == '0);
            if (winner != 3'd0) begin
                dir_nxt   = DIR_DOWN;
                upsel_nxt = 2'd0;
            end else if (gpu_local) begin
                dir_nxt   = DIR_LOOP;
                upsel_nxt = 2'd0;
            end else begin
                dir_nxt   = DIR_UP;
                upsel_nxt = up_pick;
            end
        end else if (burst_done || timeout_hit) begin
            rr_ptr_nxt  = wrap5(current_grant, 3'd1);
            if (burst_done && (direction == DIR_UP)) uplink_ptr_nxt = uplink_sel + 2'd1;
            grant_nxt   = NO_GRANT;
            onehot_nxt  = '0;
            dir_nxt     = DIR_NONE;
            upsel_nxt   = '0;
            busy_nxt    = 1'b0;
            last_nxt    = 1'b0;
            timeout_nxt = timeout_hit;
        end else if ((state == S_XFER) && beat_fire) begin
            beats_left_nxt = beats_left - 1'b1;
            last_nxt       = (beats_left == LEN_W'(1));
        end
    end
endmodule
`default_nettype wire
